// File: rtl/uart_buf_pkg.sv
// Shared types and constants for the uart byte buffer.
package uart_buf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TX_WAIT = 2'd1,
        RX_WAIT = 2'd2
    } state_t;

    localparam int DEFAULT_DEPTH = 16;
    localparam int STAT_W        = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// 8-bit synchronous first-word-fall-through FIFO with occupancy count.
// Head is read straight from storage so it is valid as soon as count != 0.
module byte_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push at full is accepted only when a pop frees the head slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_byte_buffer.sv
// Core-side byte buffer in front of the uart wrapper: TX FIFO drained one byte
// per uart transmit, RX FIFO filled by uart reads issued while rx_en is set.
// Optional build macro UART_BUF_STATS_EN adds tx_drop_cnt and rx_byte_cnt.
module uart_byte_buffer
    import uart_buf_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [7:0]    rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    input  logic          rx_en,
    output logic [CW-1:0] tx_count,
    output logic [CW-1:0] rx_count,
    input  logic          u_ready,
    output logic [7:0]    t_data,
    output logic          t_valid,
    input  logic          tx_done,
    output logic          r_valid,
    input  logic [7:0]    r_data,
    input  logic          rx_done
`ifdef UART_BUF_STATS_EN
    ,
    output logic [STAT_W-1:0] tx_drop_cnt,
    output logic [STAT_W-1:0] rx_byte_cnt
`endif
);

    state_t     state, state_nxt;
    logic       t_valid_nxt;
    logic       r_valid_nxt;
    logic [7:0] t_data_nxt;
    logic [7:0] tx_head;
    logic       tx_full;
    logic       tx_empty;
    logic       rx_full;
    logic       rx_empty;
    logic       tx_push;
    logic       tx_pop;
    logic       rx_push;
    logic       rx_pop;

    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;
    // Gate on tx_ready so a byte refused at full is never sneaked in by a same-cycle pop.
    assign tx_push  = tx_valid && tx_ready;
    assign tx_pop   = (state == TX_WAIT) && tx_done;
    assign rx_push  = (state == RX_WAIT) && rx_done;
    assign rx_pop   = rx_ready && rx_valid;

    byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (tx_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .count     (tx_count),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (r_data),
        .pop       (rx_pop),
        .head      (rx_data),
        .count     (rx_count),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    // State and registered request outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            t_valid <= 1'b0;
            r_valid <= 1'b0;
            t_data  <= '0;
        end else begin
            state   <= state_nxt;
            t_valid <= t_valid_nxt;
            r_valid <= r_valid_nxt;
            t_data  <= t_data_nxt;
        end
    end

    // Issue decision: TX wins over RX; RX only with room so the single outstanding read always fits.
    always_comb begin
        state_nxt   = state;
        t_valid_nxt = 1'b0;
        r_valid_nxt = 1'b0;
        t_data_nxt  = t_data;
        case (state)
            IDLE: begin
                if (u_ready && !tx_empty) begin
                    state_nxt   = TX_WAIT;
                    t_valid_nxt = 1'b1;
                    t_data_nxt  = tx_head;
                end else if (u_ready && rx_en && !rx_full) begin
                    state_nxt   = RX_WAIT;
                    r_valid_nxt = 1'b1;
                end
            end
            TX_WAIT: if (tx_done) state_nxt = IDLE;
            RX_WAIT: if (rx_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef UART_BUF_STATS_EN
    // Saturating statistics: refused TX pushes and accepted RX bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_drop_cnt <= '0;
            rx_byte_cnt <= '0;
        end else begin
            if (tx_valid && !tx_ready) tx_drop_cnt <= sat_inc(tx_drop_cnt);
            if (rx_push)               rx_byte_cnt <= sat_inc(rx_byte_cnt);
        end
    end
`endif

endmodule
